bf_program_filter: RTL and testbench
====================================

BF_PROGRAM_FILTER -- requirements
Module: bf_program_filter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port src_data, input, 8 bits: raw program text byte.
REQ-004 SHALL have port src_valid, input, 1 bit: src_data valid.
REQ-005 SHALL have port src_last, input, 1 bit: qualifies current src byte as the final program byte.
REQ-006 SHALL have port src_ack, output, 1 bit: byte accepted this cycle when src_valid=1.
REQ-007 SHALL have port dst_data, output, 8 bits: filtered command byte to the interpreter program-load input.
REQ-008 SHALL have port dst_valid, output, 1 bit: dst_data valid.
REQ-009 SHALL have port dst_ack, input, 1 bit: interpreter consumed dst_data.
REQ-010 SHALL have port clear, input, 1 bit: leave ERR, flush all state.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse after the terminator has been consumed.
REQ-012 SHALL have port error, output, 1 bit: program rejected; held while in ERR.
REQ-013 SHALL have port depth, output, 8 bits: current bracket nesting depth.

Function
REQ-014 SHALL implement states COLLECT, TERM, DRAIN, ERR; reset state COLLECT.
REQ-015 SHALL drive src_ack = (state==COLLECT) && (fifo_count<4), from registered count only, no same-cycle bypass.
REQ-016 SHALL treat a src transfer as src_valid && src_ack; every transferred byte is consumed, whether or not it is kept.
REQ-017 SHALL keep only 0x2B '+', 0x2D '-', 0x3C '<', 0x3E '>', 0x2E '.', 0x2C ',', 0x5B '[', 0x5D ']'; all other bytes, including 0x00, SHALL be dropped silently.
REQ-018 SHALL push each kept byte into a 4-entry FIFO; a kept byte SHALL be visible on dst_data no earlier than the next cycle.
REQ-019 SHALL increment depth on kept '[' and decrement it on kept ']'.
REQ-020 SHALL enter ERR on ']' while depth==0, or on '[' while depth==255; the offending byte SHALL NOT be pushed.
REQ-021 SHALL count kept bytes in an 8-bit length counter and enter ERR when the 256th kept byte arrives; maximum program is 255 commands plus terminator.
REQ-022 SHALL, on a transfer with src_last=1, process the byte per REQ-017..021, then go to ERR if the resulting depth!=0, else to TERM.
REQ-023 In TERM, SHALL push 0x00 once fifo_count<4, then go to DRAIN.
REQ-024 In DRAIN, SHALL wait for the FIFO to empty, then pulse done for 1 cycle, return to COLLECT, and zero depth and length.
REQ-025 SHALL drive dst_valid = (fifo_count!=0) and dst_data = FIFO head (0x00 when empty).
REQ-026 SHALL pop on dst_valid && dst_ack; simultaneous push and pop SHALL leave fifo_count unchanged and preserve order.
REQ-027 SHALL, in ERR, flush the FIFO (dst_valid=0), hold error=1 and src_ack=0, and leave ERR only on clear or rst.
REQ-028 SHALL give clear the same effect as rst, and SHALL ignore clear outside ERR.
REQ-029 SHALL wrap FIFO read/write pointers modulo 4.

Reset
REQ-030 SHALL, on rst, set state=COLLECT, fifo_count=0, pointers=0, depth=0, length=0, done=0, error=0, dst_valid=0, dst_data=0x00; src_ack=1 from the first cycle after reset.
REQ-031 SHALL abandon any in-progress program on rst asserted mid-transfer; no byte is emitted afterwards until new input arrives.

Verification
REQ-032 Bench SHALL send "+[-]." with src_last on '.' and dst_ack=1 -> dst sequence 2B 5B 2D 5D 2E 00, then done pulse, error=0.
REQ-033 Bench SHALL send "a+ b\n" (last on '\n') -> dst sequence 2B 00; 'a', ' ', '\n' acked but dropped.
REQ-034 Bench SHALL send "]" -> error=1 next cycle, no dst output, src_ack=0; then clear -> error=0, src_ack=1.
REQ-035 Bench SHALL send "[[" with last on the second '[' -> error=1, depth=2 before flush, no 0x00 emitted.
REQ-036 Bench SHALL hold dst_ack=0 and send 6 '+' -> src_ack=0 after 4 accepted; releasing dst_ack resumes transfer with order preserved.
REQ-037 Bench SHALL send 256 '+' -> 255 accepted to FIFO/dst, error=1 on the 256th.

Source files
------------

// File: rtl/bf_program_filter.sv
// rtl/bf_program_filter.sv - program text filter: keeps command bytes, checks brackets, appends 0x00 terminator
module bf_program_filter (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] src_data,
  input  logic       src_valid,
  input  logic       src_last,
  output logic       src_ack,
  output logic [7:0] dst_data,
  output logic       dst_valid,
  input  logic       dst_ack,
  input  logic       clear,
  output logic       done,
  output logic       error,
  output logic [7:0] depth
);

  typedef enum logic [1:0] {COLLECT, TERM, DRAIN, ERR} state_t;

  state_t      state, state_nxt;
  logic [7:0]  mem [0:3];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  fifo_count;
  logic [7:0]  length, length_nxt, depth_nxt;
  logic [7:0]  push_data;
  logic        push, pop, flush, done_nxt, is_cmd, xfer;

  assign src_ack   = (state == COLLECT) && !fifo_count[2];
  assign xfer      = src_valid && src_ack;
  assign dst_valid = (fifo_count != 3'd0);
  assign dst_data  = dst_valid ? mem[rd_ptr] : 8'h00;
  assign pop       = dst_valid && dst_ack;
  assign error     = (state == ERR);

  always_comb begin
    is_cmd = 1'b0;
    case (src_data)
      8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h2E, 8'h2C, 8'h5B, 8'h5D: is_cmd = 1'b1;
      default: is_cmd = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    push       = 1'b0;
    push_data  = src_data;
    depth_nxt  = depth;
    length_nxt = length;
    flush      = 1'b0;
    done_nxt   = 1'b0;
    case (state)
      COLLECT: begin
        if (xfer) begin
          if (is_cmd) begin
            // Rejected bytes are never pushed; the FIFO is flushed on entry to ERR anyway.
            if ((src_data == 8'h5D && depth == 8'd0) ||
                (src_data == 8'h5B && depth == 8'hFF) ||
                (length == 8'hFF)) begin
              state_nxt = ERR;
            end else begin
              push       = 1'b1;
              length_nxt = length + 8'd1;
              if (src_data == 8'h5B) depth_nxt = depth + 8'd1;
              else if (src_data == 8'h5D) depth_nxt = depth - 8'd1;
            end
          end
          if (src_last && state_nxt != ERR)
            state_nxt = (depth_nxt != 8'd0) ? ERR : TERM;
        end
      end
      TERM: begin
        if (!fifo_count[2]) begin
          push      = 1'b1;
          push_data = 8'h00;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_count == 3'd0) begin
          done_nxt   = 1'b1;
          state_nxt  = COLLECT;
          depth_nxt  = 8'd0;
          length_nxt = 8'd0;
        end
      end
      ERR: begin
        if (clear) begin
          state_nxt  = COLLECT;
          flush      = 1'b1;
          depth_nxt  = 8'd0;
          length_nxt = 8'd0;
        end
      end
    endcase
    if (state_nxt == ERR && state != ERR) flush = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= COLLECT;
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      fifo_count <= 3'd0;
      depth      <= 8'd0;
      length     <= 8'd0;
      done       <= 1'b0;
    end else begin
      state  <= state_nxt;
      depth  <= depth_nxt;
      length <= length_nxt;
      done   <= done_nxt;
      if (flush) begin
        wr_ptr     <= 2'd0;
        rd_ptr     <= 2'd0;
        fifo_count <= 3'd0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 2'd1;
        if (pop)  rd_ptr <= rd_ptr + 2'd1;
        case ({push, pop})
          2'b10:   fifo_count <= fifo_count + 3'd1;
          2'b01:   fifo_count <= fifo_count - 3'd1;
          default: fifo_count <= fifo_count;
        endcase
      end
    end
  end

  // Storage needs no reset: dst_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem[wr_ptr] <= push_data;
  end

endmodule

// File: tb/tb_bf_program_filter.sv
// tb/tb_bf_program_filter.sv - randomized self-checking bench for bf_program_filter
module tb_bf_program_filter;

  logic       clk, rst, src_valid, src_last, src_ack, dst_valid, dst_ack, clear, done, error;
  logic [7:0] src_data, dst_data, depth;

  bf_program_filter dut (
    .clk(clk), .rst(rst), .src_data(src_data), .src_valid(src_valid), .src_last(src_last),
    .src_ack(src_ack), .dst_data(dst_data), .dst_valid(dst_valid), .dst_ack(dst_ack),
    .clear(clear), .done(done), .error(error), .depth(depth)
  );

  int total = 0;
  int bad = 0;
  logic [7:0] prog[$];
  logic [7:0] exp_q[$];
  logic [7:0] obs[$];
  bit exp_err;
  int exp_depth;
  int done_cnt;
  bit ack_rand;
  logic ack_force;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    dst_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      dst_ack = ack_rand ? ($urandom_range(0, 3) != 0) : ack_force;
    end
  end

  initial begin
    done_cnt = 0;
    forever begin
      @(negedge clk);
      if (dst_valid && dst_ack) obs.push_back(dst_data);
      if (done) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference: walk the byte list applying the acceptance rules directly.
  task automatic model();
    int d, n;
    logic [7:0] b;
    d = 0; n = 0;
    exp_q.delete();
    exp_err = 0;
    for (int i = 0; i < prog.size(); i++) begin
      b = prog[i];
      if (b inside {8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h2E, 8'h2C, 8'h5B, 8'h5D}) begin
        if ((b == 8'h5D && d == 0) || (b == 8'h5B && d == 255) || n == 255) begin
          exp_err = 1;
          break;
        end
        exp_q.push_back(b);
        n++;
        if (b == 8'h5B) d++;
        if (b == 8'h5D) d--;
      end
      if (i == prog.size() - 1) begin
        if (d != 0) exp_err = 1;
        else exp_q.push_back(8'h00);
      end
    end
    exp_depth = d;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, output bit ok);
    ok = 0;
    repeat ($urandom_range(0, 1)) begin
      @(posedge clk);
      #1;
    end
    src_data = b; src_last = last; src_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (error) break;
      if (src_ack) begin
        @(posedge clk);
        #1;
        ok = 1;
        break;
      end
    end
    src_valid = 1'b0; src_last = 1'b0;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1; clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
  endtask

  task automatic drive_from(input int start);
    bit ok;
    for (int i = start; i < prog.size(); i++) begin
      send_byte(prog[i], i == prog.size() - 1, ok);
      if (error) break;
      if (!ok) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic finish_check(input string name);
    bit pf;
    for (int c = 0; c < 3000 && done_cnt == 0 && !error; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    if (exp_err) begin
      chk({name, "_error"}, error, 1);
      chk({name, "_err_depth"}, depth, exp_depth);
      chk({name, "_err_src_ack"}, src_ack, 0);
      chk({name, "_err_dst_valid"}, dst_valid, 0);
      chk({name, "_err_no_done"}, done_cnt, 0);
      pf = (obs.size() <= exp_q.size());
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
        if (obs[i] !== exp_q[i]) pf = 0;
      chk({name, "_err_prefix"}, pf, 1);
      pulse_clear();
      @(negedge clk);
      chk({name, "_clr_error"}, error, 0);
      chk({name, "_clr_src_ack"}, src_ack, 1);
      chk({name, "_clr_depth"}, depth, 0);
    end else begin
      chk({name, "_error"}, error, 0);
      chk({name, "_done_cnt"}, done_cnt, 1);
      chk({name, "_len"}, obs.size(), exp_q.size());
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
        chk({name, "_byte"}, obs[i], exp_q[i]);
      chk({name, "_depth"}, depth, 0);
      if (error) pulse_clear();
    end
  endtask

  task automatic run_program(input string name, input bit rnd_ack);
    model();
    ack_rand = rnd_ack; ack_force = 1'b1;
    @(posedge clk); #1;
    obs.delete(); done_cnt = 0;
    drive_from(0);
    finish_check(name);
  endtask

  task automatic set_prog(input string s);
    prog.delete();
    for (int i = 0; i < s.len(); i++) prog.push_back(s[i]);
  endtask

  initial begin
    bit ok;
    int open, len, r;
    logic [7:0] junk [5];
    junk[0] = 8'h00; junk[1] = "a"; junk[2] = " "; junk[3] = 8'h0A; junk[4] = 8'hFF;
    rst = 1'b1; clear = 1'b0; src_valid = 1'b0; src_last = 1'b0; src_data = 8'h00;
    ack_rand = 0; ack_force = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_src_ack", src_ack, 1);
    chk("rst_dst_valid", dst_valid, 0);
    chk("rst_dst_data", dst_data, 8'h00);
    chk("rst_depth", depth, 0);
    chk("rst_error", error, 0);
    chk("rst_done", done, 0);

    set_prog("+[-].");
    run_program("basic", 0);
    set_prog("a+ b\n");
    run_program("junk", 0);
    set_prog("]");
    run_program("unbal_close", 0);
    chk("unbal_close_no_out", obs.size(), 0);
    set_prog("[[");
    run_program("open_last", 0);

    // Backpressure: four bytes fill the FIFO; clear outside ERR must be ignored.
    set_prog("++++++");
    model();
    ack_rand = 0; ack_force = 1'b0;
    @(posedge clk); #1;
    obs.delete(); done_cnt = 0;
    for (int i = 0; i < 4; i++) send_byte(8'h2B, 1'b0, ok);
    repeat (3) begin @(posedge clk); #1; end
    clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
    @(negedge clk);
    chk("bp_src_ack", src_ack, 0);
    chk("bp_dst_valid", dst_valid, 1);
    chk("bp_dst_data", dst_data, 8'h2B);
    chk("bp_error", error, 0);
    ack_force = 1'b1;
    drive_from(4);
    finish_check("backpressure");

    prog.delete();
    repeat (256) prog.push_back(8'h2B);
    run_program("overlong", 0);
    chk("overlong_cnt", obs.size(), 255);

    // Reset while a program is partly buffered.
    ack_rand = 0; ack_force = 1'b0;
    for (int i = 0; i < 3; i++) send_byte(8'h3E, 1'b0, ok);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    ack_force = 1'b1;
    obs.delete();
    repeat (5) @(negedge clk);
    chk("midrst_dst_valid", dst_valid, 0);
    chk("midrst_src_ack", src_ack, 1);
    chk("midrst_no_out", obs.size(), 0);

    for (int t = 0; t < 40; t++) begin
      prog.delete();
      open = 0;
      len = $urandom_range(1, 24);
      for (int k = 0; k < len; k++) begin
        r = $urandom_range(0, 9);
        case (r)
          0: prog.push_back(8'h2B);
          1: prog.push_back(8'h2D);
          2: prog.push_back(8'h3C);
          3: prog.push_back(8'h3E);
          4: prog.push_back(8'h2E);
          5: prog.push_back(8'h2C);
          6: begin prog.push_back(8'h5B); open++; end
          7: begin
            if (open > 0 || $urandom_range(0, 9) == 0) begin
              prog.push_back(8'h5D);
              if (open > 0) open--;
            end else prog.push_back(8'h2B);
          end
          default: prog.push_back(junk[$urandom_range(0, 4)]);
        endcase
      end
      if ($urandom_range(0, 4) != 0) repeat (open) prog.push_back(8'h5D);
      run_program("rand", 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
